// File: rtl/win_detector.sv
// -----------------------------------------------------------------------------
// win_detector
//
// Purpose:
//   Sits upstream of the painter. After every placed stone it scans the board
//   outward from the last move in four directions (horizontal, vertical,
//   diagonal, anti-diagonal), looking for WIN_LEN or more same-coloured stones
//   in a row. It reports the game status and a per-cell mask of the winning
//   line, which the board controller uses to repaint those cells as
//   CHESS_WITH_WIN.
//
//   Cell values on the board bus: 0 empty, 1 black, 2 blue, 3 winning stone.
//   The scan visits one cell per clock. Every direction costs three cycles
//   (positive walk, negative walk, evaluate) plus one cycle per matching
//   neighbour. Marking a winning line costs one cycle per stone.
//
//   The status is sticky. Once a win or a draw has been reported, later start
//   requests go straight to DONE without rescanning, until Reset.
//
// Ports:
//   Clck                 in   1    clock, rising edge
//   Reset                in   1    synchronous, active-low reset
//   in_cont_signal       in   1    start request (level)
//   out_cont_signal      out  1    done; held until next_out_cont_signal
//   next_out_cont_signal in   1    downstream has consumed the result
//   board                in   512  cell (x,y) = board[y*32 + x*2 +: 2]
//   move_x, move_y       in   4    coordinates of the last placed stone
//   stone_count          in   9    stones on the board (0..256)
//   winning_information  out  2    00 gaming, 01 draw, 10 black, 11 blue
//   win_mask             out  256  bit y*16+x set = cell is in the winning line
//
//   board, move_x/move_y and stone_count must stay stable from the start
//   request until out_cont_signal rises.
// -----------------------------------------------------------------------------
module win_detector #(
  parameter int BOARD_W = 16,
  parameter int BOARD_H = 16,
  parameter int WIN_LEN = 5
) (
  input  logic                         Clck,
  input  logic                         Reset,
  input  logic                         in_cont_signal,
  output logic                         out_cont_signal,
  input  logic                         next_out_cont_signal,
  input  logic [2*BOARD_W*BOARD_H-1:0] board,
  input  logic [3:0]                   move_x,
  input  logic [3:0]                   move_y,
  input  logic [8:0]                   stone_count,
  output logic [1:0]                   winning_information,
  output logic [BOARD_W*BOARD_H-1:0]   win_mask
);

  // Cell addressing uses 4-bit coordinates, so the board is 16x16.
  localparam int         CELLS      = BOARD_W * BOARD_H;
  localparam logic [8:0] FULL_COUNT = 9'(CELLS);
  localparam logic [4:0] WIN_COUNT  = 5'(WIN_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN_POS,
    S_SCAN_NEG,
    S_EVAL,
    S_MARK,
    S_DONE
  } state_e;

  // Direction step. dir0 (+1,0), dir1 (0,+1), dir2 (+1,+1), dir3 (+1,-1).
  function automatic logic signed [4:0] delta_x(input logic [1:0] dir);
    return (dir == 2'd1) ? 5'sd0 : 5'sd1;
  endfunction

  function automatic logic signed [4:0] delta_y(input logic [1:0] dir);
    logic signed [4:0] dy;
    case (dir)
      2'd0:    dy = 5'sd0;
      2'd1:    dy = 5'sd1;
      2'd2:    dy = 5'sd1;
      default: dy = -5'sd1;
    endcase
    return dy;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,     state_d;
  logic              out_cont_q,  out_cont_d;
  logic [1:0]        win_info_q,  win_info_d;
  logic [CELLS-1:0]  win_mask_q,  win_mask_d;
  logic [1:0]        colour_q,    colour_d;
  logic [1:0]        dir_q,       dir_d;
  logic [4:0]        count_q,     count_d;
  logic [3:0]        mx_q,        mx_d;
  logic [3:0]        my_q,        my_d;
  // The cursor is signed with one spare bit. A step off either edge lands on a
  // negative value (15+1 also wraps to -16), so "off the board" is simply the
  // sign bit. The walk never steps on from an off-board cell.
  logic signed [4:0] cur_x_q,     cur_x_d;
  logic signed [4:0] cur_y_q,     cur_y_d;
  logic [3:0]        start_x_q,   start_x_d;
  logic [3:0]        start_y_q,   start_y_d;
  logic [3:0]        end_x_q,     end_x_d;
  logic [3:0]        end_y_q,     end_y_d;

  // ---------------------------------------------------------------------------
  // Board lookups
  // ---------------------------------------------------------------------------
  logic [1:0]        move_cell;
  logic [1:0]        cur_cell;
  logic              cur_in_range;
  logic              cur_match;
  logic [7:0]        cur_idx;
  logic signed [4:0] mxs;
  logic signed [4:0] mys;
  logic [1:0]        dir_next;

  assign move_cell    = board[{move_y, move_x, 1'b0} +: 2];
  assign cur_idx      = {cur_y_q[3:0], cur_x_q[3:0]};
  assign cur_cell     = board[{cur_idx, 1'b0} +: 2];
  assign cur_in_range = !cur_x_q[4] && !cur_y_q[4];
  assign cur_match    = cur_in_range && (cur_cell == colour_q);
  assign mxs          = $signed({1'b0, mx_q});
  assign mys          = $signed({1'b0, my_q});
  assign dir_next     = dir_q + 2'd1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d    = state_q;
    win_info_d = win_info_q;
    win_mask_d = win_mask_q;
    colour_d   = colour_q;
    dir_d      = dir_q;
    count_d    = count_q;
    mx_d       = mx_q;
    my_d       = my_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    start_x_d  = start_x_q;
    start_y_d  = start_y_q;
    end_x_d    = end_x_q;
    end_y_d    = end_y_q;

    case (state_q)
      S_IDLE: begin
        if (in_cont_signal && !out_cont_q) begin
          if (win_info_q != 2'b00) begin
            // The game is already decided, so report the stored result.
            state_d = S_DONE;
          end else begin
            win_mask_d = '0;
            state_d    = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        mx_d     = move_x;
        my_d     = move_y;
        colour_d = move_cell;
        if (move_cell == 2'd0 || move_cell == 2'd3) begin
          state_d = S_DONE;
        end else begin
          dir_d     = 2'd0;
          count_d   = 5'd1;
          start_x_d = move_x;
          start_y_d = move_y;
          end_x_d   = move_x;
          end_y_d   = move_y;
          cur_x_d   = $signed({1'b0, move_x}) + delta_x(2'd0);
          cur_y_d   = $signed({1'b0, move_y}) + delta_y(2'd0);
          state_d   = S_SCAN_POS;
        end
      end

      S_SCAN_POS: begin
        if (cur_match) begin
          count_d = count_q + 5'd1;
          end_x_d = cur_x_q[3:0];
          end_y_d = cur_y_q[3:0];
          cur_x_d = cur_x_q + delta_x(dir_q);
          cur_y_d = cur_y_q + delta_y(dir_q);
        end else begin
          cur_x_d = mxs - delta_x(dir_q);
          cur_y_d = mys - delta_y(dir_q);
          state_d = S_SCAN_NEG;
        end
      end

      S_SCAN_NEG: begin
        if (cur_match) begin
          count_d   = count_q + 5'd1;
          start_x_d = cur_x_q[3:0];
          start_y_d = cur_y_q[3:0];
          cur_x_d   = cur_x_q - delta_x(dir_q);
          cur_y_d   = cur_y_q - delta_y(dir_q);
        end else begin
          state_d = S_EVAL;
        end
      end

      S_EVAL: begin
        // Check for a win before checking for a draw. A full board whose last
        // stone completes a line is a win. Overlines also count.
        if (count_q >= WIN_COUNT) begin
          win_info_d = (colour_q == 2'd1) ? 2'b10 : 2'b11;
          cur_x_d    = $signed({1'b0, start_x_q});
          cur_y_d    = $signed({1'b0, start_y_q});
          state_d    = S_MARK;
        end else if (dir_q != 2'd3) begin
          dir_d     = dir_next;
          count_d   = 5'd1;
          start_x_d = mx_q;
          start_y_d = my_q;
          end_x_d   = mx_q;
          end_y_d   = my_q;
          cur_x_d   = mxs + delta_x(dir_next);
          cur_y_d   = mys + delta_y(dir_next);
          state_d   = S_SCAN_POS;
        end else begin
          win_info_d = (stone_count == FULL_COUNT) ? 2'b01 : 2'b00;
          state_d    = S_DONE;
        end
      end

      S_MARK: begin
        // The walk runs from start to end along the winning direction, so
        // every cell it visits is on the board.
        win_mask_d[cur_idx] = 1'b1;
        if (cur_x_q[3:0] == end_x_q && cur_y_q[3:0] == end_y_q) begin
          state_d = S_DONE;
        end else begin
          cur_x_d = cur_x_q + delta_x(dir_q);
          cur_y_d = cur_y_q + delta_y(dir_q);
        end
      end

      S_DONE: begin
        if (next_out_cont_signal) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Registered done flag, high in the same cycle the FSM sits in DONE.
    out_cont_d = (state_d == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clck) begin
    if (!Reset) begin
      // NOTE: win_mask is an ordinary flop bank, not a RAM, and it drives an
      // output. It is reset with the rest of the state so that an aborted
      // scan never leaves a partial line behind.
      state_q    <= S_IDLE;
      out_cont_q <= 1'b0;
      win_info_q <= 2'b00;
      win_mask_q <= '0;
      colour_q   <= 2'd0;
      dir_q      <= 2'd0;
      count_q    <= 5'd0;
      mx_q       <= 4'd0;
      my_q       <= 4'd0;
      cur_x_q    <= 5'sd0;
      cur_y_q    <= 5'sd0;
      start_x_q  <= 4'd0;
      start_y_q  <= 4'd0;
      end_x_q    <= 4'd0;
      end_y_q    <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the
      // pre-edge values no matter what order the statements are in.
      state_q    <= state_d;
      out_cont_q <= out_cont_d;
      win_info_q <= win_info_d;
      win_mask_q <= win_mask_d;
      colour_q   <= colour_d;
      dir_q      <= dir_d;
      count_q    <= count_d;
      mx_q       <= mx_d;
      my_q       <= my_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      start_x_q  <= start_x_d;
      start_y_q  <= start_y_d;
      end_x_q    <= end_x_d;
      end_y_q    <= end_y_d;
    end
  end

  assign out_cont_signal     = out_cont_q;
  assign winning_information = win_info_q;
  assign win_mask            = win_mask_q;

endmodule

// File: tb/tb_win_detector.sv
// -----------------------------------------------------------------------------
// tb_win_detector
//
// Self-checking bench for win_detector. A table of board/move vectors is run
// through the start/done handshake. The expected status, mask and latency of
// each run are queued when the start is driven, then popped and compared when
// done rises. Hand-written sequences cover reset behaviour, including a reset
// in the middle of a scan.
// -----------------------------------------------------------------------------
module tb_win_detector;

  logic         Clck;
  logic         Reset;
  logic         in_cont_signal;
  logic         out_cont_signal;
  logic         next_out_cont_signal;
  logic [511:0] board;
  logic [3:0]   move_x;
  logic [3:0]   move_y;
  logic [8:0]   stone_count;
  logic [1:0]   winning_information;
  logic [255:0] win_mask;

  win_detector dut (
    .Clck                 (Clck),
    .Reset                (Reset),
    .in_cont_signal       (in_cont_signal),
    .out_cont_signal      (out_cont_signal),
    .next_out_cont_signal (next_out_cont_signal),
    .board                (board),
    .move_x               (move_x),
    .move_y               (move_y),
    .stone_count          (stone_count),
    .winning_information  (winning_information),
    .win_mask             (win_mask)
  );

  initial Clck = 1'b0;
  always #5 Clck = ~Clck;

  typedef struct {
    string        name;
    bit           do_reset;
    logic [511:0] brd;
    logic [3:0]   mx;
    logic [3:0]   my;
    logic [8:0]   sc;
    logic [1:0]   status;
    logic [255:0] mask;
    int           lat;      // edge index at which done first shows; -1 = unchecked
  } vec_t;

  typedef struct {
    logic [1:0]   status;
    logic [255:0] mask;
    int           lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] put(input logic [511:0] b, input int x,
                                       input int y, input logic [1:0] c);
    b[y*32 + x*2 +: 2] = c;
    return b;
  endfunction

  // Full board with no run longer than two in any direction.
  function automatic logic [511:0] full_pattern();
    logic [511:0] b;
    b = '0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        b = put(b, x, y, ((((x >> 1) + y) & 1) != 0) ? 2'd2 : 2'd1);
    return b;
  endfunction

  task automatic apply_reset();
    Reset          = 1'b0;
    in_cont_signal = 1'b0;
    repeat (2) @(posedge Clck);
    @(negedge Clck);
    Reset = 1'b1;
  endtask

  // Called at a negedge. Drives one start, waits for done, checks, handshakes.
  task automatic run_vec(input vec_t v);
    exp_t e;
    int   edge_idx;
    bit   got;
    if (v.do_reset) apply_reset();
    board       = v.brd;
    move_x      = v.mx;
    move_y      = v.my;
    stone_count = v.sc;
    sb.push_back('{status: v.status, mask: v.mask, lat: v.lat});
    in_cont_signal = 1'b1;
    edge_idx = -1;
    got      = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge Clck);
      edge_idx++;
      @(negedge Clck);
      if (out_cont_signal) begin
        got = 1'b1;
        break;
      end
    end
    in_cont_signal = 1'b0;
    e = sb.pop_front();
    check({v.name, " done seen"}, 256'(got), 256'(1));
    if (got) begin
      check({v.name, " status"}, 256'(winning_information), 256'(e.status));
      check({v.name, " mask"}, win_mask, e.mask);
      if (e.lat >= 0) check({v.name, " latency"}, 256'(edge_idx), 256'(e.lat));
      repeat (3) @(negedge Clck);
      check({v.name, " done held"}, 256'(out_cont_signal), 256'(1));
      check({v.name, " status held"}, 256'(winning_information), 256'(e.status));
      next_out_cont_signal = 1'b1;
      @(posedge Clck);
      @(negedge Clck);
      next_out_cont_signal = 1'b0;
      check({v.name, " done drop"}, 256'(out_cont_signal), 256'(0));
    end else begin
      apply_reset();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] single_b, row_b, blue_b, four_b, full_b, fullwin_b, three_b;
    logic [255:0] blue_m;
    vec_t         blue_v;

    single_b = put('0, 7, 7, 2'd1);
    row_b = '0;
    for (int x = 0; x < 5; x++) row_b = put(row_b, x, 0, 2'd1);
    blue_b = '0;
    for (int k = 0; k < 5; k++) blue_b = put(blue_b, 11 + k, 4 - k, 2'd2);
    blue_b = put(blue_b, 0, 15, 2'd2);   // trap for a cursor that wraps
    blue_m = '0;
    blue_m[75] = 1'b1; blue_m[60] = 1'b1; blue_m[45] = 1'b1;
    blue_m[30] = 1'b1; blue_m[15] = 1'b1;
    four_b = '0;
    for (int x = 0; x < 4; x++) four_b = put(four_b, x, 5, 2'd1);
    full_b    = full_pattern();
    fullwin_b = put(put(full_b, 2, 0, 2'd1), 3, 0, 2'd1);  // black run x=0..5
    three_b   = put('0, 5, 5, 2'd3);

    blue_v = '{"blue diag", 1'b1, blue_b, 4'd13, 4'd2, 9'd6, 2'b11, blue_m, 22};

    vecs.push_back('{"single", 1'b1, single_b, 4'd7, 4'd7, 9'd1, 2'b00, 256'h0, 13});
    vecs.push_back('{"row five", 1'b1, row_b, 4'd4, 4'd0, 9'd5, 2'b10, 256'h1f, 13});
    vecs.push_back('{"sticky", 1'b0, row_b, 4'd4, 4'd0, 9'd5, 2'b10, 256'h1f, 0});
    vecs.push_back(blue_v);
    vecs.push_back('{"four only", 1'b1, four_b, 4'd3, 4'd5, 9'd4, 2'b00, 256'h0, 16});
    vecs.push_back('{"full draw", 1'b1, full_b, 4'd7, 4'd7, 9'd256, 2'b01, 256'h0, -1});
    vecs.push_back('{"full 255", 1'b1, full_b, 4'd7, 4'd7, 9'd255, 2'b00, 256'h0, -1});
    vecs.push_back('{"full win", 1'b1, fullwin_b, 4'd2, 4'd0, 9'd256, 2'b10, 256'h3f, 15});
    vecs.push_back('{"empty move", 1'b1, single_b, 4'd9, 4'd9, 9'd1, 2'b00, 256'h0, 1});
    vecs.push_back('{"colour 3", 1'b1, three_b, 4'd5, 4'd5, 9'd1, 2'b00, 256'h0, 1});

    // Reset held with start high: nothing may be taken.
    Reset                = 1'b0;
    in_cont_signal       = 1'b1;
    next_out_cont_signal = 1'b0;
    board                = single_b;
    move_x               = 4'd7;
    move_y               = 4'd7;
    stone_count          = 9'd1;
    repeat (2) @(posedge Clck);
    @(negedge Clck);
    check("reset done", 256'(out_cont_signal), 256'(0));
    check("reset status", 256'(winning_information), 256'(0));
    check("reset mask", win_mask, 256'h0);
    in_cont_signal = 1'b0;
    Reset          = 1'b1;
    repeat (20) @(negedge Clck);
    check("no start taken", 256'(out_cont_signal), 256'(0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during SCAN_POS of dir2 (entered at edge 7 on the blue board).
    apply_reset();
    board          = blue_b;
    move_x         = 4'd13;
    move_y         = 4'd2;
    stone_count    = 9'd6;
    in_cont_signal = 1'b1;
    repeat (8) @(posedge Clck);
    @(negedge Clck);
    Reset          = 1'b0;
    in_cont_signal = 1'b0;
    @(posedge Clck);
    @(negedge Clck);
    check("abort done", 256'(out_cont_signal), 256'(0));
    check("abort status", 256'(winning_information), 256'(0));
    check("abort mask", win_mask, 256'h0);
    repeat (20) @(negedge Clck);
    Reset = 1'b1;
    repeat (30) @(negedge Clck);
    check("abort no result", 256'(out_cont_signal), 256'(0));
    check("abort no status", 256'(winning_information), 256'(0));
    blue_v.name     = "rescan";
    blue_v.do_reset = 1'b0;
    run_vec(blue_v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
